// File: rtl/ecc_serial_wrapper.sv
// ecc_serial_wrapper: bit-serial loader, affine double-and-add scalar
// multiplier over GF(p) and bit-serial result shifter.
//
// Handshake: i_data_valid is a one-cycle start strobe and is honoured only
// in IDLE. There is no ready signal. The caller may strobe again from the
// cycle after the last result bit. o_data_valid marks only the result MSB
// cycle. The remaining N-1 bits follow on consecutive cycles.

module ecc_serial_wrapper #(
   parameter int MAX_BITS = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic i_data_valid,
   input  logic i_mode,
   input  logic i_a,
   input  logic i_prime,
   input  logic i_Px,
   input  logic i_Py,
   input  logic i_m,
   output logic o_data_valid,
   output logic o_Px,
   output logic o_Py
);

   localparam int W  = MAX_BITS;
   localparam int CW = $clog2(MAX_BITS + 1);
   localparam logic [CW-1:0] W_C = CW'(MAX_BITS);

   typedef enum logic [2:0] {IDLE, MODE1, MODE0, LOAD, COMPUTE, OUTPUT} state_t;

   // Compute micro-sequencer: each point operation is
   // slope -> inverse -> lambda -> lambda^2 -> x3 -> y3.
   // C_MUL is a shared multiply loop that returns to mul_ret.
   typedef enum logic [3:0] {
      C_NEXT_BIT, C_DBL, C_DBL_NUM, C_ADD, C_INV, C_LAM, C_X3, C_Y3, C_MUL
   } cstate_t;

   state_t  state, state_next;
   cstate_t cstate, cstate_next, mul_ret;

   logic          configured, q_inf, cur_bit, doing_add;
   logic [1:0]    mode_r;
   logic [CW-1:0] cnt, scan_cnt, mul_cnt;
   logic [W-1:0]  a_r, p_r, px_r, py_r, m_r, m_scan, qx, qy, num, x3_r;
   logic [W-1:0]  mul_a, mul_b, mul_r, inv_u, inv_v, inv_x1, inv_x2, out_x, out_y;

   logic [CW-1:0] n_bits, align;
   logic          last_cnt, scan_done, mul_done, inv_zero, inv_done;
   logic [W-1:0]  m_loaded, mul_dbl, mul_next, inv_res, other_x, x3_calc, dbl_num;

   function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, y, pm);
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, pm}) s = s - {1'b0, pm};
      return s[W-1:0];
   endfunction

   // Operands are already reduced, so one conditional +p suffices.
   function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, y, pm);
      return (x >= y) ? (x - y) : (x - y + pm);
   endfunction

   // x/2 mod p for odd p: add p first when x is odd.
   function automatic logic [W-1:0] mod_half(input logic [W-1:0] x, pm);
      logic [W:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, pm}) : {1'b0, x};
      return s[W:1];
   endfunction

   // Width code 00..11 selects 16, 32, 64 or 128 bits.
   // align moves bit N-1 to the MSB.
   assign n_bits    = CW'(16) << mode_r;
   assign align     = W_C - n_bits;
   assign last_cnt  = (cnt == n_bits - CW'(1));
   assign scan_done = (scan_cnt == '0);
   assign m_loaded  = configured ? m_r : {m_r[W-2:0], i_m};

   // Interleaved multiply step: r = 2r (+a when the next multiplier bit is set).
   assign mul_dbl  = mod_add(mul_r, mul_r, p_r);
   assign mul_next = mul_b[W-1] ? mod_add(mul_dbl, mul_a, p_r) : mul_dbl;
   assign mul_done = (mul_cnt == '0);

   // A zero operand or a non-unit gcd drives u or v to zero.
   // Stopping there keeps the inversion bounded for bad inputs.
   assign inv_zero = (inv_u == '0) || (inv_v == '0);
   assign inv_done = inv_zero || (inv_u == W'(1)) || (inv_v == W'(1));
   assign inv_res  = inv_zero ? '0 : ((inv_u == W'(1)) ? inv_x1 : inv_x2);

   // x3 = lambda^2 - x1 - x2, where x2 = x1 when doubling.
   assign other_x = doing_add ? px_r : qx;
   assign x3_calc = mod_sub(mod_sub(mul_r, qx, p_r), other_x, p_r);
   assign dbl_num = mod_add(mod_add(mod_add(mul_r, mul_r, p_r), mul_r, p_r), a_r, p_r);

   assign o_data_valid = (state == OUTPUT) && (cnt == '0);
   assign o_Px         = (state == OUTPUT) && out_x[W-1];
   assign o_Py         = (state == OUTPUT) && out_y[W-1];

   // State registers for the top-level FSM and the compute sequencer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cstate <= C_NEXT_BIT;
      end else begin
         state  <= state_next;
         cstate <= cstate_next;
      end
   end

   // Next-state logic for the top-level FSM and the compute sequencer.
   always_comb begin
      state_next  = state;
      cstate_next = cstate;
      case (state)
         IDLE:    if (i_data_valid) state_next = configured ? LOAD : MODE1;
         MODE1:   state_next = MODE0;
         MODE0:   state_next = LOAD;
         LOAD:    if (last_cnt) state_next = COMPUTE;
         COMPUTE: if (cstate == C_NEXT_BIT && scan_done) state_next = OUTPUT;
         OUTPUT:  if (last_cnt) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (state != COMPUTE) begin
         cstate_next = C_NEXT_BIT;
      end else begin
         case (cstate)
            C_NEXT_BIT: if (!scan_done) cstate_next = C_DBL;
            C_DBL:      cstate_next = (q_inf || qy == '0) ? (cur_bit ? C_ADD : C_NEXT_BIT) : C_MUL;
            C_DBL_NUM:  cstate_next = C_INV;
            C_ADD: begin
               if (q_inf)           cstate_next = C_NEXT_BIT;
               else if (qx == px_r) cstate_next = (qy == py_r) ? C_DBL : C_NEXT_BIT;
               else                 cstate_next = C_INV;
            end
            C_INV:   if (inv_done) cstate_next = C_MUL;
            C_LAM:   cstate_next = C_MUL;
            C_X3:    cstate_next = C_MUL;
            C_Y3:    cstate_next = (!doing_add && cur_bit) ? C_ADD : C_NEXT_BIT;
            C_MUL:   if (mul_done) cstate_next = mul_ret;
            default: cstate_next = C_NEXT_BIT;
         endcase
      end
   end

   // Datapath: serial load, point arithmetic and result shift-out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         configured <= 1'b0;  mode_r <= '0;   cnt <= '0;  scan_cnt <= '0;  mul_cnt <= '0;
         q_inf <= 1'b0;  cur_bit <= 1'b0;  doing_add <= 1'b0;  mul_ret <= C_NEXT_BIT;
         a_r <= '0;  p_r <= '0;  px_r <= '0;  py_r <= '0;  m_r <= '0;  m_scan <= '0;
         qx <= '0;  qy <= '0;  num <= '0;  x3_r <= '0;  mul_a <= '0;  mul_b <= '0;
         mul_r <= '0;  inv_u <= '0;  inv_v <= '0;  inv_x1 <= '0;  inv_x2 <= '0;
         out_x <= '0;  out_y <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_data_valid) begin
                  cnt  <= '0;
                  px_r <= '0;
                  py_r <= '0;
                  if (!configured) begin
                     a_r <= '0;
                     p_r <= '0;
                     m_r <= '0;
                  end
               end
            end
            MODE1: mode_r[1] <= i_mode;
            MODE0: mode_r[0] <= i_mode;
            LOAD: begin
               px_r <= {px_r[W-2:0], i_Px};
               py_r <= {py_r[W-2:0], i_Py};
               if (!configured) begin
                  a_r <= {a_r[W-2:0], i_a};
                  p_r <= {p_r[W-2:0], i_prime};
                  m_r <= m_loaded;
               end
               cnt <= cnt + CW'(1);
               if (last_cnt) begin
                  configured <= 1'b1;
                  q_inf      <= 1'b1;
                  qx         <= '0;
                  qy         <= '0;
                  m_scan     <= m_loaded << align;
                  scan_cnt   <= n_bits;
               end
            end
            COMPUTE: begin
               case (cstate)
                  C_NEXT_BIT: begin
                     if (scan_done) begin
                        out_x <= q_inf ? '0 : (qx << align);
                        out_y <= q_inf ? '0 : (qy << align);
                        cnt   <= '0;
                     end else begin
                        cur_bit  <= m_scan[W-1];
                        m_scan   <= m_scan << 1;
                        scan_cnt <= scan_cnt - CW'(1);
                     end
                  end
                  C_DBL: begin
                     doing_add <= 1'b0;
                     if (q_inf || qy == '0) begin
                        q_inf <= 1'b1;
                     end else begin
                        mul_a   <= qx;
                        mul_b   <= qx << align;
                        mul_r   <= '0;
                        mul_cnt <= n_bits;
                        mul_ret <= C_DBL_NUM;
                     end
                  end
                  C_DBL_NUM: begin
                     num    <= dbl_num;
                     inv_u  <= mod_add(qy, qy, p_r);
                     inv_v  <= p_r;
                     inv_x1 <= W'(1);
                     inv_x2 <= '0;
                  end
                  C_ADD: begin
                     doing_add <= 1'b1;
                     if (q_inf) begin
                        qx    <= px_r;
                        qy    <= py_r;
                        q_inf <= 1'b0;
                     end else if (qx == px_r) begin
                        // Q == P: double instead and do not add again. Q == -P: infinity.
                        if (qy == py_r) cur_bit <= 1'b0;
                        else            q_inf   <= 1'b1;
                     end else begin
                        num    <= mod_sub(py_r, qy, p_r);
                        inv_u  <= mod_sub(px_r, qx, p_r);
                        inv_v  <= p_r;
                        inv_x1 <= W'(1);
                        inv_x2 <= '0;
                     end
                  end
                  C_INV: begin
                     if (inv_done) begin
                        mul_a   <= num;
                        mul_b   <= inv_res << align;
                        mul_r   <= '0;
                        mul_cnt <= n_bits;
                        mul_ret <= C_LAM;
                     end else if (!inv_u[0]) begin
                        inv_u  <= inv_u >> 1;
                        inv_x1 <= mod_half(inv_x1, p_r);
                     end else if (!inv_v[0]) begin
                        inv_v  <= inv_v >> 1;
                        inv_x2 <= mod_half(inv_x2, p_r);
                     end else if (inv_u >= inv_v) begin
                        inv_u  <= inv_u - inv_v;
                        inv_x1 <= mod_sub(inv_x1, inv_x2, p_r);
                     end else begin
                        inv_v  <= inv_v - inv_u;
                        inv_x2 <= mod_sub(inv_x2, inv_x1, p_r);
                     end
                  end
                  C_LAM: begin
                     mul_a   <= mul_r;
                     mul_b   <= mul_r << align;
                     mul_r   <= '0;
                     mul_cnt <= n_bits;
                     mul_ret <= C_X3;
                  end
                  C_X3: begin
                     // mul_a still holds lambda from the squaring.
                     x3_r    <= x3_calc;
                     mul_b   <= mod_sub(qx, x3_calc, p_r) << align;
                     mul_r   <= '0;
                     mul_cnt <= n_bits;
                     mul_ret <= C_Y3;
                  end
                  C_Y3: begin
                     qx    <= x3_r;
                     qy    <= mod_sub(mul_r, qy, p_r);
                     q_inf <= 1'b0;
                  end
                  C_MUL: begin
                     if (!mul_done) begin
                        mul_r   <= mul_next;
                        mul_b   <= mul_b << 1;
                        mul_cnt <= mul_cnt - CW'(1);
                     end
                  end
                  default: ;
               endcase
            end
            OUTPUT: begin
               out_x <= out_x << 1;
               out_y <= out_y << 1;
               cnt   <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_serial_wrapper.sv
// Bench for ecc_serial_wrapper: directed curve cases plus random curves,
// checked against an affine group-law model that uses repeated addition.
module tb_ecc_serial_wrapper;

   logic clk = 1'b0;
   logic rst;
   logic i_data_valid = 1'b0, i_mode = 1'b0, i_a = 1'b0, i_prime = 1'b0;
   logic i_Px = 1'b0, i_Py = 1'b0, i_m = 1'b0;
   logic o_data_valid, o_Px, o_Py;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [255:0] exp_q[$];

   localparam int WAIT_LIMIT = 60000;

   ecc_serial_wrapper #(.MAX_BITS(128)) dut (
      .clk(clk), .rst(rst), .i_data_valid(i_data_valid), .i_mode(i_mode),
      .i_a(i_a), .i_prime(i_prime), .i_Px(i_Px), .i_Py(i_Py), .i_m(i_m),
      .o_data_valid(o_data_valid), .o_Px(o_Px), .o_Py(o_Py)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic longint md(input longint v, input longint p);
      return ((v % p) + p) % p;
   endfunction

   // Inverse by Fermat: x^(p-2) mod p.
   function automatic longint minv(input longint x, input longint p);
      longint r, b, e;
      r = 1;
      b = md(x, p);
      e = p - 2;
      while (e > 0) begin
         if (e[0]) r = (r * b) % p;
         b = (b * b) % p;
         e = e >> 1;
      end
      return r;
   endfunction

   task automatic pt_add(input longint p, a, x1, y1, input bit i1,
                         input longint x2, y2, input bit i2,
                         output longint x3, y3, output bit i3);
      longint lam;
      x3 = 0; y3 = 0; i3 = 1'b0;
      if (i1) begin
         x3 = x2; y3 = y2; i3 = i2;
      end else if (i2) begin
         x3 = x1; y3 = y1; i3 = i1;
      end else if (x1 == x2 && md(y1 + y2, p) == 0) begin
         i3 = 1'b1;
      end else begin
         if (x1 == x2)
            lam = (md(3 * md(x1 * x1, p) + a, p) * minv(2 * y1, p)) % p;
         else
            lam = (md(y2 - y1, p) * minv(x2 - x1, p)) % p;
         x3 = md((lam * lam) % p - x1 - x2, p);
         y3 = md((lam * md(x1 - x3, p)) % p - y1, p);
      end
   endtask

   // m*P by adding P to the point at infinity m times.
   task automatic model_mul(input longint p, a, px, py, input int m,
                            output logic [255:0] res);
      longint qx, qy, nx, ny;
      bit qi, ni;
      qx = 0; qy = 0; qi = 1'b1;
      for (int k = 0; k < m; k++) begin
         pt_add(p, a, qx, qy, qi, px, py, 1'b0, nx, ny, ni);
         qx = nx; qy = ny; qi = ni;
      end
      if (qi) res = '0;
      else    res = {128'(qx), 128'(qy)};
   endtask

   // ---------------- drivers ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic drive_full(input logic [1:0] mode, input logic [127:0] a, p, px, py, m);
      int n;
      n = 16 << mode;
      @(negedge clk);
      i_data_valid = 1'b1;
      @(negedge clk);
      i_data_valid = 1'b0;
      i_mode = mode[1];
      @(negedge clk);
      i_mode = mode[0];
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         i_a = a[i]; i_prime = p[i]; i_Px = px[i]; i_Py = py[i]; i_m = m[i];
      end
   endtask

   task automatic drive_point(input int n, input logic [127:0] px, py, input bit no_wait);
      if (!no_wait) @(negedge clk);
      i_data_valid = 1'b1;
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         i_data_valid = 1'b0;
         i_Px = px[i]; i_Py = py[i];
      end
   endtask

   // Scoreboard: wait for the pulse, collect N bits, compare to the head of exp_q.
   task automatic collect(input int n, input string name);
      logic [255:0] expv;
      logic [127:0] gx, gy;
      int waited;
      bit extra;
      expv = exp_q.pop_front();
      waited = 0;
      extra = 1'b0;
      gx = '0;
      gy = '0;
      @(negedge clk);
      while (o_data_valid !== 1'b1 && waited < WAIT_LIMIT) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (o_data_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: no o_data_valid within %0d cycles, required one pulse", name, WAIT_LIMIT);
         return;
      end
      for (int i = n - 1; i >= 0; i--) begin
         if (i != n - 1) begin
            @(negedge clk);
            if (o_data_valid !== 1'b0) extra = 1'b1;
         end
         gx[i] = o_Px;
         gy[i] = o_Py;
      end
      n_cmp++;
      if ({gx, gy} !== expv) begin
         n_fail++;
         $display("FAIL %s_result: got Qx=%0h Qy=%0h, required Qx=%0h Qy=%0h",
                  name, gx, gy, expv[255:128], expv[127:0]);
      end
      n_cmp++;
      if (extra) begin
         n_fail++;
         $display("FAIL %s_pulse: o_data_valid high after the MSB cycle, required a single pulse", name);
      end
      @(negedge clk);
      n_cmp++;
      if ({o_data_valid, o_Px, o_Py} !== 3'b000) begin
         n_fail++;
         $display("FAIL %s_idle: got valid/x/y=%b%b%b after last bit, required 000",
                  name, o_data_valid, o_Px, o_Py);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int bad;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({o_data_valid, o_Px, o_Py} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_hold: got valid/x/y=%b%b%b, required 000", o_data_valid, o_Px, o_Py);
      end
      rst = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if ({o_data_valid, o_Px, o_Py} !== 3'b000) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL reset_idle: %0d idle cycles with nonzero outputs, required 0", bad);
      end
   endtask

   task automatic test_full_then_point();
      exp_q.push_back({128'd6, 128'd3});
      drive_full(2'b00, 128'd2, 128'd17, 128'd5, 128'd1, 128'd2);
      collect(16, "full_m2");
      repeat (4) @(negedge clk);
      exp_q.push_back({128'd3, 128'd1});
      drive_point(16, 128'd6, 128'd3, 1'b0);
      collect(16, "point_reuse_m");
   endtask

   task automatic test_group_order();
      int           ms[3]   = '{19, 1, 7};
      logic [255:0] exps[3] = '{256'd0, {128'd5, 128'd1}, {128'd0, 128'd6}};
      for (int k = 0; k < 3; k++) begin
         apply_reset();
         exp_q.push_back(exps[k]);
         drive_full(2'b00, 128'd2, 128'd17, 128'd5, 128'd1, 128'(ms[k]));
         collect(16, $sformatf("order_m%0d", ms[k]));
      end
   endtask

   task automatic test_widths();
      for (int md_i = 1; md_i <= 3; md_i++) begin
         apply_reset();
         exp_q.push_back({128'd7, 128'd6});
         drive_full(2'(md_i), 128'd2, 128'd17, 128'd5, 128'd1, 128'd9);
         collect(16 << md_i, $sformatf("width_n%0d", 16 << md_i));
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      exp_q.push_back({128'd5, 128'd1});
      drive_full(2'b00, 128'd2, 128'd17, 128'd5, 128'd1, 128'd1);
      collect(16, "b2b_full");
      exp_q.push_back({128'd6, 128'd3});
      drive_point(16, 128'd6, 128'd3, 1'b1);
      collect(16, "b2b_point1");
      exp_q.push_back({128'd10, 128'd6});
      drive_point(16, 128'd10, 128'd6, 1'b1);
      collect(16, "b2b_point2");
   endtask

   task automatic test_reset_mid_compute();
      int bad;
      apply_reset();
      drive_full(2'b00, 128'd2, 128'd17, 128'd5, 128'd1, 128'd7);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({o_data_valid, o_Px, o_Py} !== 3'b000) begin
         n_fail++;
         $display("FAIL midreset_now: got valid/x/y=%b%b%b, required 000", o_data_valid, o_Px, o_Py);
      end
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if ({o_data_valid, o_Px, o_Py} !== 3'b000) bad++;
      end
      rst = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if ({o_data_valid, o_Px, o_Py} !== 3'b000) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL midreset_quiet: %0d cycles with output activity, required 0", bad);
      end
      // A point-only reading of this stream would take P from the mode/a slots and use m=0.
      // With the configured flag cleared, the stream must be taken as a full load.
      exp_q.push_back({128'd0, 128'd6});
      drive_full(2'b00, 128'd2, 128'd17, 128'd5, 128'd1, 128'd7);
      collect(16, "midreset_full");
   endtask

   task automatic test_random();
      longint primes[6] = '{17, 251, 4093, 65521, 1000003, 2147483647};
      longint p, a, x, y;
      int m, n;
      logic [1:0] mode;
      logic [255:0] expv;
      for (int it = 0; it < 5; it++) begin
         p = primes[$urandom_range(0, 5)];
         mode = (p < 65536) ? 2'($urandom_range(0, 1)) : 2'd1;
         n = 16 << mode;
         a = longint'($urandom_range(0, 32'(p - 1)));
         x = longint'($urandom_range(0, 32'(p - 1)));
         y = longint'($urandom_range(0, 32'(p - 1)));
         m = $urandom_range(0, 31);
         apply_reset();
         model_mul(p, a, x, y, m, expv);
         exp_q.push_back(expv);
         drive_full(mode, 128'(a), 128'(p), 128'(x), 128'(y), 128'(m));
         collect(n, $sformatf("rand%0d_full_p%0d_m%0d", it, p, m));
         x = longint'($urandom_range(0, 32'(p - 1)));
         y = longint'($urandom_range(0, 32'(p - 1)));
         model_mul(p, a, x, y, m, expv);
         exp_q.push_back(expv);
         drive_point(n, 128'(x), 128'(y), it[0]);
         collect(n, $sformatf("rand%0d_point", it));
      end
   endtask

   initial begin
      test_reset();
      test_full_then_point();
      test_group_order();
      test_widths();
      test_back_to_back();
      test_reset_mid_compute();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
